// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter multiplexing NUM_PORTS requesters onto the single-outstanding DRAM controller
// user port; one transaction in flight, read data returned, hung commands aborted after TIMEOUT.
module dram_port_arbiter #(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MASK_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0] wmask,
  output logic [NUM_PORTS-1:0]            ack,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic [NUM_PORTS-1:0]            err,
  output logic                            busy,
  input  logic                            dram_calib,
  input  logic                            dram_ready,
  output logic                            dram_rd_en,
  output logic                            dram_wr_en,
  output logic [ADDR_WIDTH-1:0]           dram_addr,
  output logic [DATA_WIDTH-1:0]           dram_wdata,
  output logic [MASK_WIDTH-1:0]           dram_mask,
  input  logic [DATA_WIDTH-1:0]           dram_rdata,
  input  logic                            dram_rvalid
);

  localparam int unsigned IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   rr, rr_next, idx, pick;
  logic            pick_valid;
  logic            lat_we;
  logic [CW-1:0]   cnt, cnt_inc;
  logic            grant, done_ok, done_to, cap_rd;

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];
  logic [MASK_WIDTH-1:0] wmask_a [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign wmask_a[g] = wmask[g*MASK_WIDTH +: MASK_WIDTH];
  end

  // First requester at or after the rr pointer, wrapping past the last port.
  always_comb begin
    int unsigned p;
    logic [IW-1:0] p_idx;
    pick       = '0;
    pick_valid = 1'b0;
    p          = 0;
    p_idx      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      p = 32'(rr) + i;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      p_idx = IW'(p);
      if (!pick_valid && req[p_idx]) begin
        pick_valid = 1'b1;
        pick       = p_idx;
      end
    end
  end

  assign rr_next = (32'(idx) == NUM_PORTS - 1) ? '0 : idx + IW'(1);
  assign cnt_inc = (cnt == CW'(TIMEOUT)) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The cycle carrying ack never grants, so a requester still holding req during its ack is not re-served.
  // Timeout fires once SETTLE/WAIT cycles reach TIMEOUT; ack then lands TIMEOUT+1 cycles after the command.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    cap_rd     = 1'b0;
    case (state)
      IDLE: begin
        if (dram_calib && dram_ready && pick_valid && !(|ack)) begin
          grant      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:  state_next = SETTLE;
      SETTLE: state_next = WAIT;
      WAIT: begin
        if (!lat_we && dram_rvalid) begin
          done_ok    = 1'b1;
          cap_rd     = 1'b1;
          state_next = IDLE;
        end else if (lat_we && dram_ready) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          done_to    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr         <= '0;
      idx        <= '0;
      lat_we     <= 1'b0;
      cnt        <= '0;
      ack        <= '0;
      err        <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      dram_rd_en <= 1'b0;
      dram_wr_en <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_mask  <= '0;
    end else begin
      busy       <= (state_next != IDLE);
      dram_rd_en <= grant && !we[pick];
      dram_wr_en <= grant && we[pick];
      ack        <= '0;
      err        <= '0;
      if (grant) begin
        idx        <= pick;
        lat_we     <= we[pick];
        dram_addr  <= addr_a[pick];
        dram_wdata <= wdata_a[pick];
        dram_mask  <= wmask_a[pick];
      end
      if (state == ISSUE) cnt <= '0;
      else if (state == SETTLE || state == WAIT) cnt <= cnt_inc;
      if (cap_rd) rdata <= dram_rdata;
      if (done_ok || done_to) begin
        ack <= NUM_PORTS'(1) << idx;
        rr  <= rr_next;
      end
      if (done_to) err <= NUM_PORTS'(1) << idx;
    end
  end

endmodule
